// File: rtl/link_xfr_sm.sv
// link_xfr_sm
//   Read-side transfer state machine for the link FIFO (PCIe/read clock).
//   Moves one complete 4KB block (BLK_BEATS x 256-bit words) per DMA slot
//   from the link FIFO into the host DPL ring buffer. It also maintains the
//   host ring producer index against the host consumer index.
//
// Ports
//   clk, rst             : read clock, synchronous active-high reset
//   iLKF_FIFO_NEMPTY     : link FIFO holds at least one complete block
//   oXFR_AHEAD_ST        : one-cycle read-ahead strobe (prefetch first word)
//   oDPLBUF_DATA_V       : beat valid toward the DPL buffer
//   oXFR_DMA_REQ         : DMA slot request, held until granted
//   oXFR_DMA_ADDR        : 4KB-aligned host byte address of target block
//   iDMA_XFR_GNT         : one-cycle grant pulse from the DMA arbiter
//   iREG_XFR_EN          : transfer enable
//   iREG_RING_BASE       : ring base address bits [63:12]
//   iREG_RING_SIZE       : ring size in blocks
//   iREG_RING_RD_IDX     : host consumer index
//   oXFR_REG_WR_IDX      : producer index (next block slot)
//   oXFR_REG_BLK_CNT     : total blocks transferred (wraps)
//   oXFR_REG_RING_FULL   : ring full, transfer stalled
module link_xfr_sm #(
  parameter int RING_IDX_WIDTH = 10,
  parameter int BLK_BEATS      = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      iLKF_FIFO_NEMPTY,
  output logic                      oXFR_AHEAD_ST,
  output logic                      oDPLBUF_DATA_V,
  output logic                      oXFR_DMA_REQ,
  output logic [63:0]               oXFR_DMA_ADDR,
  input  logic                      iDMA_XFR_GNT,
  input  logic                      iREG_XFR_EN,
  input  logic [51:0]               iREG_RING_BASE,
  input  logic [RING_IDX_WIDTH:0]   iREG_RING_SIZE,
  input  logic [RING_IDX_WIDTH-1:0] iREG_RING_RD_IDX,
  output logic [RING_IDX_WIDTH-1:0] oXFR_REG_WR_IDX,
  output logic [31:0]               oXFR_REG_BLK_CNT,
  output logic                      oXFR_REG_RING_FULL
);

  localparam int BEAT_W = $clog2(BLK_BEATS);
  localparam logic [BEAT_W-1:0]         BEAT_LAST = BEAT_W'(BLK_BEATS - 1);
  localparam logic [BEAT_W-1:0]         BEAT_ONE  = BEAT_W'(1);
  localparam logic [RING_IDX_WIDTH-1:0] IDX_ONE   = RING_IDX_WIDTH'(1);
  localparam logic [RING_IDX_WIDTH:0]   SIZE_ONE  = (RING_IDX_WIDTH + 1)'(1);
  localparam logic [RING_IDX_WIDTH:0]   SIZE_TWO  = (RING_IDX_WIDTH + 1)'(2);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    AHEAD,
    DATA,
    DONE
  } state_t;

  state_t                    state;
  logic [BEAT_W-1:0]         beat;
  logic [RING_IDX_WIDTH:0]   size_m1;
  logic [RING_IDX_WIDTH-1:0] wr_idx_nxt;
  logic                      ring_full;
  logic [63:0]               blk_addr;

  // Producer index wraps at the last ring slot; one slot always stays empty,
  // and rings smaller than two blocks can never hold data.
  always_comb begin
    size_m1    = iREG_RING_SIZE - SIZE_ONE;
    wr_idx_nxt = ({1'b0, oXFR_REG_WR_IDX} == size_m1) ? '0 : oXFR_REG_WR_IDX + IDX_ONE;
    ring_full  = (iREG_RING_SIZE < SIZE_TWO) | (wr_idx_nxt == iREG_RING_RD_IDX);
    // 64-bit add, carry out of bit 63 discarded.
    blk_addr   = {iREG_RING_BASE, 12'h000}
               + {{(52 - RING_IDX_WIDTH){1'b0}}, oXFR_REG_WR_IDX, 12'h000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      beat               <= '0;
      oXFR_AHEAD_ST      <= 1'b0;
      oDPLBUF_DATA_V     <= 1'b0;
      oXFR_DMA_REQ       <= 1'b0;
      oXFR_DMA_ADDR      <= '0;
      oXFR_REG_WR_IDX    <= '0;
      oXFR_REG_BLK_CNT   <= '0;
      oXFR_REG_RING_FULL <= 1'b0;
    end else begin
      oXFR_REG_RING_FULL <= ring_full;
      case (state)
        IDLE: begin
          // Disabled ring restarts from slot 0; software resets RD_IDX to match.
          if (!iREG_XFR_EN) begin
            oXFR_REG_WR_IDX <= '0;
          end
          if (iREG_XFR_EN && iLKF_FIFO_NEMPTY && !ring_full) begin
            state         <= REQ;
            oXFR_DMA_REQ  <= 1'b1;
            oXFR_DMA_ADDR <= blk_addr;
          end
        end
        REQ: begin
          // Request is never withdrawn once raised, enable or not.
          if (iDMA_XFR_GNT) begin
            state         <= AHEAD;
            oXFR_DMA_REQ  <= 1'b0;
            oXFR_AHEAD_ST <= 1'b1;
          end
        end
        AHEAD: begin
          state          <= DATA;
          oXFR_AHEAD_ST  <= 1'b0;
          oDPLBUF_DATA_V <= 1'b1;
          beat           <= '0;
        end
        DATA: begin
          if (beat == BEAT_LAST) begin
            state          <= DONE;
            oDPLBUF_DATA_V <= 1'b0;
            beat           <= '0;
          end else begin
            beat <= beat + BEAT_ONE;
          end
        end
        DONE: begin
          state            <= IDLE;
          oXFR_REG_WR_IDX  <= wr_idx_nxt;
          oXFR_REG_BLK_CNT <= oXFR_REG_BLK_CNT + 32'd1;
        end
        default: begin
          state          <= IDLE;
          oXFR_AHEAD_ST  <= 1'b0;
          oDPLBUF_DATA_V <= 1'b0;
          oXFR_DMA_REQ   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_xfr_sm.sv
module tb_link_xfr_sm;

  localparam int W = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        iLKF_FIFO_NEMPTY;
  logic        oXFR_AHEAD_ST;
  logic        oDPLBUF_DATA_V;
  logic        oXFR_DMA_REQ;
  logic [63:0] oXFR_DMA_ADDR;
  logic        iDMA_XFR_GNT;
  logic        iREG_XFR_EN;
  logic [51:0] iREG_RING_BASE;
  logic [W:0]  iREG_RING_SIZE;
  logic [W-1:0] iREG_RING_RD_IDX;
  logic [W-1:0] oXFR_REG_WR_IDX;
  logic [31:0] oXFR_REG_BLK_CNT;
  logic        oXFR_REG_RING_FULL;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [63:0] BASE_ADDR = 64'h0000_0001_0000_0000;

  link_xfr_sm #(.RING_IDX_WIDTH(W), .BLK_BEATS(128)) dut (
    .clk                (clk),
    .rst                (rst),
    .iLKF_FIFO_NEMPTY   (iLKF_FIFO_NEMPTY),
    .oXFR_AHEAD_ST      (oXFR_AHEAD_ST),
    .oDPLBUF_DATA_V     (oDPLBUF_DATA_V),
    .oXFR_DMA_REQ       (oXFR_DMA_REQ),
    .oXFR_DMA_ADDR      (oXFR_DMA_ADDR),
    .iDMA_XFR_GNT       (iDMA_XFR_GNT),
    .iREG_XFR_EN        (iREG_XFR_EN),
    .iREG_RING_BASE     (iREG_RING_BASE),
    .iREG_RING_SIZE     (iREG_RING_SIZE),
    .iREG_RING_RD_IDX   (iREG_RING_RD_IDX),
    .oXFR_REG_WR_IDX    (oXFR_REG_WR_IDX),
    .oXFR_REG_BLK_CNT   (oXFR_REG_BLK_CNT),
    .oXFR_REG_RING_FULL (oXFR_REG_RING_FULL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(input string tag, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (oXFR_DMA_REQ) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic no_req(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (oXFR_DMA_REQ) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  // Entered at a negedge where REQ is visible; leaves at the negedge of the
  // IDLE cycle following DONE (index and count already updated).
  task automatic run_block(input string tag, input int gap, input logic [63:0] exp_addr);
    int beats;
    int overlap;
    chk({tag, "_addr"}, oXFR_DMA_ADDR, exp_addr);
    repeat (gap) @(negedge clk);
    chk({tag, "_req_held"}, 64'(oXFR_DMA_REQ), 64'd1);
    iDMA_XFR_GNT = 1'b1;
    @(negedge clk);
    iDMA_XFR_GNT = 1'b0;
    chk({tag, "_ahead"}, {61'd0, oXFR_AHEAD_ST, oXFR_DMA_REQ, oDPLBUF_DATA_V}, 64'b100);
    beats   = 0;
    overlap = 0;
    @(negedge clk);
    while (oDPLBUF_DATA_V && beats < 200) begin
      if (oXFR_AHEAD_ST || oXFR_DMA_REQ) overlap++;
      beats++;
      @(negedge clk);
    end
    chk({tag, "_beats"}, 64'(beats), 64'd128);
    chk({tag, "_overlap"}, 64'(overlap), 64'd0);
    @(negedge clk);
    chk({tag, "_gap_dv"}, 64'(oDPLBUF_DATA_V), 64'd0);
  endtask

  initial begin
    int beats;
    rst              = 1'b1;
    iLKF_FIFO_NEMPTY = 1'b1;
    iDMA_XFR_GNT     = 1'b0;
    iREG_XFR_EN      = 1'b1;
    iREG_RING_BASE   = 52'h10_0000;
    iREG_RING_SIZE   = 11'd4;
    iREG_RING_RD_IDX = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ctl", {60'd0, oXFR_AHEAD_ST, oDPLBUF_DATA_V, oXFR_DMA_REQ, oXFR_REG_RING_FULL}, 64'd0);
    chk("rst_addr", oXFR_DMA_ADDR, 64'd0);
    chk("rst_wr_idx", 64'(oXFR_REG_WR_IDX), 64'd0);
    chk("rst_blk_cnt", 64'(oXFR_REG_BLK_CNT), 64'd0);
    rst = 1'b0;

    // Single block, grant 3 cycles after REQ
    wait_req("b1_req", 5);
    run_block("b1", 3, BASE_ADDR);
    chk("b1_wr_idx", 64'(oXFR_REG_WR_IDX), 64'd1);
    chk("b1_blk_cnt", 64'(oXFR_REG_BLK_CNT), 64'd1);

    // Back-to-back blocks with immediate grants until the ring fills
    wait_req("b2_req", 5);
    run_block("b2", 0, BASE_ADDR + 64'h1000);
    wait_req("b3_req", 5);
    run_block("b3", 0, BASE_ADDR + 64'h2000);
    chk("b3_wr_idx", 64'(oXFR_REG_WR_IDX), 64'd3);
    @(negedge clk);
    chk("b3_full", 64'(oXFR_REG_RING_FULL), 64'd1);
    no_req("b3_stall", 20);

    // Host consumes one block; last slot is used and the index wraps
    iREG_RING_RD_IDX = 10'd1;
    wait_req("b4_req", 5);
    run_block("b4", 0, BASE_ADDR + 64'h3000);
    chk("b4_wr_wrap", 64'(oXFR_REG_WR_IDX), 64'd0);
    chk("b4_blk_cnt", 64'(oXFR_REG_BLK_CNT), 64'd4);
    no_req("b4_stall", 10);

    // Rings of one and zero blocks are always full
    iREG_XFR_EN      = 1'b0;
    iREG_RING_RD_IDX = '0;
    iREG_RING_SIZE   = 11'd1;
    @(negedge clk);
    iREG_XFR_EN = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("size1_full", 64'(oXFR_REG_RING_FULL), 64'd1);
    no_req("size1_noreq", 20);
    iREG_XFR_EN    = 1'b0;
    iREG_RING_SIZE = 11'd0;
    @(negedge clk);
    iREG_XFR_EN = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("size0_full", 64'(oXFR_REG_RING_FULL), 64'd1);
    no_req("size0_noreq", 20);

    // Enable dropped while requesting: block completes, then index clears
    iREG_XFR_EN    = 1'b0;
    iREG_RING_SIZE = 11'd4;
    @(negedge clk);
    iREG_XFR_EN = 1'b1;
    wait_req("en_req", 5);
    iREG_XFR_EN = 1'b0;
    run_block("en", 10, BASE_ADDR);
    chk("en_wr_idx", 64'(oXFR_REG_WR_IDX), 64'd1);
    chk("en_blk_cnt", 64'(oXFR_REG_BLK_CNT), 64'd5);
    @(negedge clk);
    chk("en_wr_clr", 64'(oXFR_REG_WR_IDX), 64'd0);
    no_req("en_noreq", 5);

    // Reset in the middle of the DATA phase
    iREG_XFR_EN = 1'b1;
    wait_req("mr_req", 5);
    iDMA_XFR_GNT = 1'b1;
    @(negedge clk);
    iDMA_XFR_GNT = 1'b0;
    beats = 0;
    @(negedge clk);
    while (oDPLBUF_DATA_V && beats < 50) begin
      beats++;
      @(negedge clk);
    end
    chk("mr_beats", 64'(beats), 64'd50);
    chk("mr_dv_before", 64'(oDPLBUF_DATA_V), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_ctl", {61'd0, oXFR_AHEAD_ST, oDPLBUF_DATA_V, oXFR_DMA_REQ}, 64'd0);
    chk("mr_addr", oXFR_DMA_ADDR, 64'd0);
    chk("mr_wr_idx", 64'(oXFR_REG_WR_IDX), 64'd0);
    chk("mr_blk_cnt", 64'(oXFR_REG_BLK_CNT), 64'd0);

    // Block counter rollover
    iREG_XFR_EN = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    force dut.oXFR_REG_BLK_CNT = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.oXFR_REG_BLK_CNT;
    @(negedge clk);
    chk("wrap_preload", 64'(oXFR_REG_BLK_CNT), 64'hFFFF_FFFF);
    iREG_XFR_EN = 1'b1;
    wait_req("wrap_req", 5);
    run_block("wrap", 1, BASE_ADDR);
    chk("wrap_blk_cnt", 64'(oXFR_REG_BLK_CNT), 64'd0);
    chk("wrap_wr_idx", 64'(oXFR_REG_WR_IDX), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
